// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared line memory; one transaction in flight.
// Optional read timeout reporting is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int XLEN    = 32,
    parameter int ADR_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p0_req_v,
    output logic             p0_req_rdy,
    input  logic             p0_we,
    input  logic [ADR_W-1:0] p0_adr,
    input  logic [XLEN-1:0]  p0_wdata,
    input  logic [3:0]       p0_strb,
    output logic             p0_rsp_v,
    output logic [XLEN-1:0]  p0_rdata,
    output logic             p0_err,
    input  logic             p1_req_v,
    output logic             p1_req_rdy,
    input  logic             p1_we,
    input  logic [ADR_W-1:0] p1_adr,
    input  logic [XLEN-1:0]  p1_wdata,
    input  logic [3:0]       p1_strb,
    output logic             p1_rsp_v,
    output logic [XLEN-1:0]  p1_rdata,
    output logic             p1_err,
    output logic             m_r_v,
    output logic             m_w_v,
    output logic [ADR_W-1:0] m_adr,
    output logic [XLEN-1:0]  m_data,
    output logic [3:0]       m_strobe,
    input  logic [XLEN-1:0]  m_resp,
    input  logic             m_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       state;
    logic             last_grant;
    logic             owner;
    logic             we_q;
    logic [ADR_W-1:0] adr_q;
    logic [XLEN-1:0]  wdata_q;
    logic [3:0]       strb_q;
    logic [XLEN-1:0]  rdata_q;
    logic             gnt0;
    logic             gnt1;
    logic             issue;
    logic             rsp;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;
`endif

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n && state == S_IDLE) begin
            if (p0_req_v && (!p1_req_v || last_grant))
                gnt0 = 1'b1;
            else if (p1_req_v)
                gnt1 = 1'b1;
        end
    end

    assign p0_req_rdy = gnt0;
    assign p1_req_rdy = gnt1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            rdata_q    <= '0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt   <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (gnt0 || gnt1) begin
                        owner      <= gnt1;
                        last_grant <= gnt1;
                        we_q       <= gnt1 ? p1_we    : p0_we;
                        adr_q      <= gnt1 ? p1_adr   : p0_adr;
                        wdata_q    <= gnt1 ? p1_wdata : p0_wdata;
                        strb_q     <= gnt1 ? p1_strb  : p0_strb;
                        rdata_q    <= '0;
`ifdef MEM_TIMEOUT_EN
                        err_q      <= 1'b0;
`endif
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef MEM_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= we_q ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    if (m_ack) begin
                        rdata_q <= m_resp;
                        state   <= S_RESP;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign issue    = (state == S_ISSUE);
    assign rsp      = (state == S_RESP);
    assign m_r_v    = issue && !we_q;
    assign m_w_v    = issue && we_q;
    assign m_adr    = issue ? adr_q   : '0;
    assign m_data   = issue ? wdata_q : '0;
    assign m_strobe = issue ? strb_q  : '0;

    assign p0_rsp_v = rsp && !owner;
    assign p1_rsp_v = rsp && owner;
    assign p0_rdata = p0_rsp_v ? rdata_q : '0;
    assign p1_rdata = p1_rsp_v ? rdata_q : '0;
`ifdef MEM_TIMEOUT_EN
    assign p0_err   = p0_rsp_v && err_q;
    assign p1_err   = p1_rsp_v && err_q;
`else
    assign p0_err   = 1'b0;
    assign p1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requesters push expectations, a monitor pops and compares.
// The timeout scenario runs only when MEM_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  pv, pwe;
    logic [31:0] padr [2];
    logic [31:0] pwd  [2];
    logic [3:0]  pst  [2];
    logic        p0_req_rdy, p1_req_rdy, p0_rsp_v, p1_rsp_v, p0_err, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        m_r_v, m_w_v, m_ack;
    logic [31:0] m_adr, m_data, m_resp;
    logic [3:0]  m_strobe;

    mem_port_arbiter #(.XLEN(32), .ADR_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_v(pv[0]), .p0_req_rdy(p0_req_rdy), .p0_we(pwe[0]), .p0_adr(padr[0]),
        .p0_wdata(pwd[0]), .p0_strb(pst[0]), .p0_rsp_v(p0_rsp_v), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req_v(pv[1]), .p1_req_rdy(p1_req_rdy), .p1_we(pwe[1]), .p1_adr(padr[1]),
        .p1_wdata(pwd[1]), .p1_strb(pst[1]), .p1_rsp_v(p1_rsp_v), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .m_r_v(m_r_v), .m_w_v(m_w_v), .m_adr(m_adr), .m_data(m_data), .m_strobe(m_strobe),
        .m_resp(m_resp), .m_ack(m_ack)
    );

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
        int unsigned at;
    } rsp_t;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] data;
        logic [3:0]  strb;
        int unsigned at;
    } mem_t;

    rsp_t rsp_q[$];
    mem_t mem_q[$];
    logic grant_log[$];

    int unsigned cyc = 0;
    int passed = 0;
    int total  = 0;
    bit mon_en = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory content model: 0x20010 reads back 0xDEADBEEF.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hDEAFBEFF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory responder: acks a read ack_k cycles after its strobe cycle.
    bit          ack_en = 1;
    bit          man_ack = 0;
    bit          pend = 0;
    int unsigned ack_k = 2;
    int unsigned ack_at = 0;
    logic [31:0] ack_adr = '0;

    always @(negedge clk) begin
        if (m_r_v === 1'b1 && ack_en) begin
            pend    = 1;
            ack_at  = cyc + ack_k;
            ack_adr = m_adr;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pend && cyc == ack_at) begin
            m_ack  = 1'b1;
            m_resp = memfn(ack_adr);
            pend   = 0;
        end else if (man_ack) begin
            m_ack  = 1'b1;
            m_resp = 32'h1234_5678;
        end else begin
            m_ack  = 1'b0;
            m_resp = '0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (mon_en && rst_n === 1'b1) begin
            if (m_r_v || m_w_v) begin
                if (mem_q.size() == 0) check("mem_unexpected", 1, 0);
                else begin
                    mem_t e;
                    e = mem_q.pop_front();
                    check("mem_cycle", cyc, e.at);
                    check("mem_kind", {m_w_v, m_r_v}, {e.we, !e.we});
                    check("mem_adr", m_adr, e.adr);
                    check("mem_data", m_data, e.data);
                    check("mem_strobe", m_strobe, e.strb);
                end
            end
            if (p0_rsp_v || p1_rsp_v) begin
                if (rsp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    rsp_t r;
                    r = rsp_q.pop_front();
                    check("rsp_cycle", cyc, r.at);
                    check("rsp_port", {p1_rsp_v, p0_rsp_v}, r.port ? 2'b10 : 2'b01);
                    check("rsp_rdata", r.port ? p1_rdata : p0_rdata, r.rdata);
                    check("rsp_err", r.port ? p1_err : p0_err, r.err);
                    check("rsp_nonowner", r.port ? {p0_rdata, p0_err} : {p1_rdata, p1_err}, 0);
                end
            end
            if (p0_req_rdy || p1_req_rdy)
                check("rdy_only_idle", {p0_req_rdy & p1_req_rdy, m_r_v | m_w_v, p0_rsp_v | p1_rsp_v}, 0);
        end
    end

    // mode 0: normal response expected, 1: none expected, 2: timeout error expected
    task automatic req(input int p, input logic we, input logic [31:0] adr, input logic [31:0] wd,
                       input logic [3:0] st, input int mode);
        mem_t m;
        rsp_t r;
        bit   got = 0;
        padr[p] = adr; pwd[p] = wd; pst[p] = st; pwe[p] = we; pv[p] = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((p == 0) ? p0_req_rdy : p1_req_rdy) begin
                got    = 1;
                m.we   = we; m.adr = adr; m.data = wd; m.strb = st; m.at = cyc + 1;
                mem_q.push_back(m);
                grant_log.push_back(p[0]);
                r.port = p[0];
                if (mode == 0) begin
                    r.rdata = we ? 32'h0 : memfn(adr);
                    r.err   = 1'b0;
                    r.at    = we ? cyc + 2 : cyc + 2 + ack_k;
                    rsp_q.push_back(r);
                end else if (mode == 2) begin
                    r.rdata = 32'h0;
                    r.err   = 1'b1;
                    r.at    = cyc + 2 + 16;
                    rsp_q.push_back(r);
                end
            end
        end
        if (!got) check("grant_timeout", 0, 1);
        @(posedge clk); #1;
        pv[p] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] order;
        rst_n = 1'b0;
        pv = 2'b11; pwe = 2'b00;
        padr[0] = '0; padr[1] = '0; pwd[0] = '0; pwd[1] = '0; pst[0] = '0; pst[1] = '0;
        m_ack = 1'b0; m_resp = '0;

        repeat (3) begin
            @(negedge clk);
            check("reset_outputs",
                  |{p0_req_rdy, p1_req_rdy, p0_rsp_v, p1_rsp_v, p0_rdata, p1_rdata, p0_err, p1_err,
                    m_r_v, m_w_v, m_adr, m_data, m_strobe}, 1'b0);
        end
        rst_n = 1'b1;
        #1;
        check("first_grant_p0", {p1_req_rdy, p0_req_rdy}, 2'b01);
        pv = 2'b00;
        mon_en = 1;
        @(posedge clk); #1;

        // single write from port 1
        req(1, 1'b1, 32'h0002_0010, 32'hDEAD_BEEF, 4'hF, 0);
        repeat (3) @(posedge clk); #1;

        // single read from port 0; an ack in the strobe cycle must not count
        ack_k = 2;
        req(0, 1'b0, 32'h0002_0010, 32'h0, 4'h0, 0);
        #1; m_ack = 1'b1; m_resp = 32'hBAD0_BAD0;
        repeat (5) @(posedge clk); #1;

        // read abandoned by reset while waiting; a late ack must produce nothing
        ack_en = 0;
        req(0, 1'b0, 32'h0000_0100, 32'h0, 4'h3, 1);
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        man_ack = 1;
        @(posedge clk); #2;
        man_ack = 0;
        repeat (4) @(posedge clk); #1;
        ack_en = 1;

        // contention: both ports stream reads, grants must alternate starting with p0
        ack_k = 1;
        grant_log.delete();
        fork
            begin
                req(0, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 0);
                req(0, 1'b0, 32'h0000_1008, 32'h0, 4'hF, 0);
            end
            begin
                req(1, 1'b0, 32'h0000_2004, 32'h0, 4'h1, 0);
                req(1, 1'b0, 32'h0000_200C, 32'h0, 4'h2, 0);
            end
        join
        repeat (6) @(posedge clk); #1;
        order = 4'hF;
        if (grant_log.size() == 4)
            order = {grant_log[0], grant_log[1], grant_log[2], grant_log[3]};
        check("grant_order", order, 4'b0101);

`ifdef MEM_TIMEOUT_EN
        ack_en = 0;
        req(1, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 2);
        repeat (18) @(posedge clk); #1;
        man_ack = 1;
        @(posedge clk); #2;
        man_ack = 0;
        repeat (5) @(posedge clk); #1;
        ack_en = 1;
`endif

        repeat (4) @(posedge clk); #1;
        check("rsp_queue_drained", rsp_q.size(), 0);
        check("mem_queue_drained", mem_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the shared 4-word-line data memory (cache_32x4 interface: r_v/w_v/adr/data/strobe in, resp/ack out).
- Port 0 is instruction fetch, port 1 is load/store. Each port has a valid/ready request channel and a one-cycle response pulse.
- Allows one transaction in flight. Grants round-robin. Drives the memory request strobes for exactly one cycle, then waits for read ack.

Parameters:
- XLEN, 32, data width of requests and responses
- ADR_W, 32, address width
- TIMEOUT, 16, cycles to wait for m_ack before reporting an error (used only with MEM_TIMEOUT_EN); must be ≥2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- p0_req_v  in  1  port 0 request valid
- p0_req_rdy  out  1  port 0 request accepted when high with p0_req_v
- p0_we  in  1  1=write, 0=read
- p0_adr  in  ADR_W  byte address
- p0_wdata  in  XLEN  write data
- p0_strb  in  4  byte enables for write
- p0_rsp_v  out  1  one-cycle response pulse
- p0_rdata  out  XLEN  read data, valid with p0_rsp_v
- p0_err  out  1  timeout error, valid with p0_rsp_v
- p1_*  same nine signals for port 1
- m_r_v  out  1  memory read strobe
- m_w_v  out  1  memory write strobe
- m_adr  out  ADR_W  memory address
- m_data  out  XLEN  memory write data
- m_strobe  out  4  memory byte enables
- m_resp  in  XLEN  memory read data
- m_ack  in  1  memory read complete

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE, last_grant=1 (port 0 wins first).
  - All outputs 0, latched request cleared.
  - An in-flight transaction is abandoned with no rsp_v.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE, arbitration (combinational):
  - Only one port valid: grant that port.
  - Both valid: grant the port ≠ last_grant.
  - pX_req_rdy=1 only for the granted port, only in IDLE. Never both high.
- Handshake at cycle N (req_v && req_rdy):
  - Latch port id, we, adr, wdata, strb.
  - Update last_grant.
  - Go to ISSUE.
- ISSUE (cycle N+1):
  - m_r_v=!we, m_w_v=we, m_adr/m_data/m_strobe driven from the latch.
  - Strobes are high this cycle only; 0 in every other state.
  - Write: next state RESP. Read: next state WAIT.
- WAIT:
  - Stay until m_ack=1 at a posedge; on that edge capture m_resp, then go to RESP.
  - m_ack seen in any other state is ignored.
  - m_ack seen in the ISSUE cycle is not counted.
- RESP:
  - Owner's pX_rsp_v=1 for one cycle, with pX_rdata = captured data (0 for writes) and pX_err=0.
  - Next state IDLE. No new grant in RESP, so back-to-back requests are spaced ≥3 cycles apart.
- Latency:
  - Write: rsp_v at N+2.
  - Read with m_ack at N+1+k (k≥1): rsp_v at N+2+k.
- Non-owner outputs: rsp_v=0, rdata=0, err=0.
- Requests held with req_v while not granted must stay stable. A requester may drop req_v before grant without effect.
- Addresses and strobes are passed unmodified. Alignment is the memory's concern.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no m_ack, go to RESP with pX_err=1 and pX_rdata=0.
  - A late m_ack after the timeout is ignored.
- Undefined: WAIT is unbounded, pX_err is tied 0, and no counter exists.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both req_v=1 -> all outputs 0, no rdy. First cycle after release -> p0_req_rdy=1.
- Single write: p1 write adr=0x20010, wdata=0xDEADBEEF, strb=4'hF at N -> m_w_v=1 with same values at N+1 only; p1_rsp_v at N+2, p1_err=0.
- Single read: p0 read adr=0x20010, m_ack with m_resp=0xDEADBEEF two cycles after m_r_v -> p0_rsp_v one cycle later with p0_rdata=0xDEADBEEF; p1_rsp_v stays 0.
- Contention: both ports request reads continuously for 4 transactions -> grants alternate p0, p1, p0, p1; each rsp_v goes to the correct port; rdy never asserted outside IDLE.
- Reset mid-read: assert rst_n=0 during WAIT, then pulse m_ack after release -> no rsp_v, state IDLE, next grant is p0.
- With MEM_TIMEOUT_EN and TIMEOUT=16: read with no m_ack -> rsp_v with err=1 and rdata=0 after 16 WAIT cycles; m_ack at cycle 20 is ignored.
